// File: rtl/seg_display_ctrl.sv
// -----------------------------------------------------------------------------
// seg_display_ctrl
//
// Multi-digit seven-segment display controller for the ALU result path.
// A captured WIDTH-bit result is formatted as hexadecimal or as decimal.
// Decimal mode can be signed and blanks leading zeros. The formatted codes
// go into a display buffer, and DIGITS multiplexed displays are scanned
// through one shared active-low segment bus.
//
// Parameters
//   WIDTH     result width in bits (4..32)
//   DIGITS    number of physical digits (1..8)
//   SCAN_DIV  clock cycles per digit while scanning (>= 1)
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous reset, active-high
//   value      result to display
//   mode       0 = hex, 1 = decimal
//   signed_en  decimal mode only: treat value as two's complement
//   load       capture request for value / mode / signed_en
//   busy       high while a capture is being formatted
//   segments   active-low segments, [6]=a .. [0]=g
//   digit_en   active-low one-hot digit select, bit 0 = least-significant
// -----------------------------------------------------------------------------
module seg_display_ctrl #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  value,
    input  logic              mode,
    input  logic              signed_en,
    input  logic              load,
    output logic              busy,
    output logic [6:0]        segments,
    output logic [DIGITS-1:0] digit_en
);

    // Decimal digits needed for a WIDTH-bit magnitude (0.3 slightly
    // under-estimates log10(2), and the +1 covers it for WIDTH <= 32). The
    // BCD register is never narrower than the display, so the formatter can
    // index every digit position directly.
    localparam int NBCD_MIN = (WIDTH * 3) / 10 + 1;
    localparam int NB       = (NBCD_MIN > DIGITS) ? NBCD_MIN : DIGITS;
    localparam int BW       = NB * 4;
    localparam int HEXW     = DIGITS * 4;
    localparam int CW       = $clog2(WIDTH);
    localparam int IW       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // Buffer codes: 0..15 are hex glyphs, then the two special glyphs.
    typedef logic [4:0] code_t;
    localparam code_t CODE_BLANK = 5'd16;
    localparam code_t CODE_MINUS = 5'd17;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_FORMAT
    } state_t;

    state_t                   state_q, state_d;
    logic                     busy_q, busy_d;
    logic                     mode_q, mode_d;
    logic                     neg_q, neg_d;
    logic [WIDTH-1:0]         data_q, data_d;   // hex value, or magnitude being shifted out
    logic [BW-1:0]            bcd_q, bcd_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [DIGITS-1:0][4:0]   buf_q, buf_d;
    logic [PW-1:0]            presc_q, presc_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [6:0]               seg_q, seg_d;
    logic [DIGITS-1:0]        dig_q, dig_d;

    logic [WIDTH-1:0]         mag;
    logic [BW-1:0]            bcd_adj;
    logic [HEXW-1:0]          hex_ext;
    logic [DIGITS-1:0][4:0]   hex_codes;
    logic [DIGITS-1:0][4:0]   dec_codes;
    logic                     dec_ovf;
    int                       msd;
    int                       usable;

    function automatic logic [6:0] glyph(input code_t c);
        case (c)
            5'd0:    glyph = 7'b0000001;
            5'd1:    glyph = 7'b1001111;
            5'd2:    glyph = 7'b0010010;
            5'd3:    glyph = 7'b0000110;
            5'd4:    glyph = 7'b1001100;
            5'd5:    glyph = 7'b0100100;
            5'd6:    glyph = 7'b0100000;
            5'd7:    glyph = 7'b0001111;
            5'd8:    glyph = 7'b0000000;
            5'd9:    glyph = 7'b0000100;
            5'd10:   glyph = 7'b0001000;
            5'd11:   glyph = 7'b1100000;
            5'd12:   glyph = 7'b0110001;
            5'd13:   glyph = 7'b1000010;
            5'd14:   glyph = 7'b0110000;
            5'd15:   glyph = 7'b0111000;
            5'd17:   glyph = 7'b1111110;
            default: glyph = 7'b1111111;
        endcase
    endfunction

    // Magnitude of a negative two's-complement value. WIDTH bits are enough:
    // the largest magnitude is 2^(WIDTH-1), which still fits unsigned.
    assign mag = (signed_en && value[WIDTH-1]) ? (~value + WIDTH'(1)) : value;

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int k = 0; k < NB; k++) begin
            if (bcd_q[4*k +: 4] >= 4'd5) begin
                bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Formatter for both bases, evaluated continuously and committed only on
    // the FORMAT exit edge.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        hex_ext   = HEXW'(data_q);
        hex_codes = '0;
        dec_codes = '0;
        dec_ovf   = 1'b0;
        msd       = 0;
        usable    = neg_q ? DIGITS - 1 : DIGITS;

        for (int k = 0; k < NB; k++) begin
            if (bcd_q[4*k +: 4] != 4'd0) begin
                msd = k;
                if (k >= usable) begin
                    dec_ovf = 1'b1;
                end
            end
        end

        for (int i = 0; i < DIGITS; i++) begin
            hex_codes[i] = {1'b0, hex_ext[4*i +: 4]};
            if (dec_ovf) begin
                dec_codes[i] = CODE_MINUS;
            end else if (i <= msd) begin
                dec_codes[i] = {1'b0, bcd_q[4*i +: 4]};
            end else if (neg_q && (i == msd + 1)) begin
                dec_codes[i] = CODE_MINUS;
            end else begin
                dec_codes[i] = CODE_BLANK;
            end
        end
    end

    // Next-state logic for the FSM, capture registers, buffer and scan.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        neg_d   = neg_q;
        data_d  = data_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;

        // Scan runs regardless of the FSM; outputs follow the index one cycle later.
        if (presc_q == PW'(SCAN_DIV - 1)) begin
            presc_d = '0;
            idx_d   = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end else begin
            presc_d = presc_q + PW'(1);
            idx_d   = idx_q;
        end
        seg_d = glyph(buf_q[idx_q]);
        dig_d = ~(DIGITS'(1) << idx_q);

        case (state_q)
            S_IDLE: begin
                if (load) begin
                    mode_d  = mode;
                    neg_d   = signed_en & value[WIDTH-1];
                    data_d  = mode ? mag : value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = mode ? S_CONV : S_FORMAT;
                end
            end
            S_CONV: begin
                // Truncating cast drops the bit shifted out of the top nibble.
                bcd_d  = BW'({bcd_adj, data_q[WIDTH-1]});
                data_d = data_q << 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FORMAT;
                end
            end
            S_FORMAT: begin
                buf_d   = mode_q ? dec_codes : hex_codes;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: all state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            mode_q  <= 1'b0;
            neg_q   <= 1'b0;
            data_q  <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            // NOTE: the display buffer is reset (unlike a typical memory)
            // because it is visible on the segment bus right after reset.
            buf_q   <= {DIGITS{CODE_BLANK}};
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= 7'h7F;
            dig_q   <= ~DIGITS'(1);
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            mode_q  <= mode_d;
            neg_q   <= neg_d;
            data_q  <= data_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            dig_q   <= dig_d;
        end
    end

    assign busy     = busy_q;
    assign segments = seg_q;
    assign digit_en = dig_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg_display_ctrl
//
// Self-checking bench for seg_display_ctrl (WIDTH=8, DIGITS=3, SCAN_DIV=4).
// An arithmetic model of the display (integer divide/modulo for decimal,
// shifts for hex, plain counters for the scan) is compared against the DUT
// outputs on every cycle. Directed tests add literal expectations for the
// busy length, the digit glyphs and the scan pattern.
// -----------------------------------------------------------------------------
module tb_seg_display_ctrl;

    localparam int WIDTH    = 8;
    localparam int DIGITS   = 3;
    localparam int SCAN_DIV = 4;

    typedef logic [DIGITS-1:0][6:0] disp_t;

    localparam logic [6:0] G_BLANK = 7'b1111111;
    localparam logic [6:0] G_MINUS = 7'b1111110;

    logic              clk = 1'b0;
    logic              rst;
    logic [WIDTH-1:0]  value;
    logic              mode;
    logic              signed_en;
    logic              load;
    logic              busy;
    logic [6:0]        segments;
    logic [DIGITS-1:0] digit_en;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    seg_display_ctrl #(
        .WIDTH   (WIDTH),
        .DIGITS  (DIGITS),
        .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .mode     (mode),
        .signed_en(signed_en),
        .load     (load),
        .busy     (busy),
        .segments (segments),
        .digit_en (digit_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    function automatic logic [6:0] hex_glyph(input int d);
        case (d)
            0:  return 7'b0000001;
            1:  return 7'b1001111;
            2:  return 7'b0010010;
            3:  return 7'b0000110;
            4:  return 7'b1001100;
            5:  return 7'b0100100;
            6:  return 7'b0100000;
            7:  return 7'b0001111;
            8:  return 7'b0000000;
            9:  return 7'b0000100;
            10: return 7'b0001000;
            11: return 7'b1100000;
            12: return 7'b0110001;
            13: return 7'b1000010;
            14: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    // What the display must show for one capture, from plain arithmetic.
    function automatic disp_t model_glyphs(input logic [WIDTH-1:0] v, input logic m, input logic s);
        disp_t  r;
        longint vv;
        longint mag;
        longint lim;
        longint q;
        int     nd;
        int     u;
        bit     neg;
        vv = longint'(v);
        if (!m) begin
            for (int i = 0; i < DIGITS; i++) r[i] = hex_glyph(int'((vv >> (4 * i)) % 16));
        end else begin
            neg = s && v[WIDTH-1];
            mag = neg ? ((longint'(1) << WIDTH) - vv) : vv;
            u   = neg ? DIGITS - 1 : DIGITS;
            lim = 1;
            for (int k = 0; k < u; k++) lim = lim * 10;
            if (mag >= lim) begin
                for (int i = 0; i < DIGITS; i++) r[i] = G_MINUS;
            end else begin
                nd = 1;
                q  = mag / 10;
                while (q != 0) begin
                    nd++;
                    q = q / 10;
                end
                q = mag;
                for (int i = 0; i < DIGITS; i++) begin
                    if (i < nd)                r[i] = hex_glyph(int'(q % 10));
                    else if (neg && i == nd)   r[i] = G_MINUS;
                    else                       r[i] = G_BLANK;
                    q = q / 10;
                end
            end
        end
        return r;
    endfunction

    int                m_busy_left;
    int                m_presc;
    int                m_idx;
    disp_t             m_buf;
    disp_t             m_pend;
    logic [6:0]        m_seg;
    logic [DIGITS-1:0] m_dig;

    always @(posedge clk) begin
        if (rst) begin
            m_busy_left <= 0;
            m_presc     <= 0;
            m_idx       <= 0;
            m_buf       <= '1;
            m_seg       <= G_BLANK;
            m_dig       <= ~DIGITS'(1);
        end else begin
            m_seg <= m_buf[m_idx];
            m_dig <= ~(DIGITS'(1) << m_idx);
            if (m_presc == SCAN_DIV - 1) begin
                m_presc <= 0;
                m_idx   <= (m_idx + 1) % DIGITS;
            end else begin
                m_presc <= m_presc + 1;
            end
            if (m_busy_left > 0) begin
                m_busy_left <= m_busy_left - 1;
                if (m_busy_left == 1) m_buf <= m_pend;
            end else if (load) begin
                m_pend      <= model_glyphs(value, mode, signed_en);
                m_busy_left <= mode ? WIDTH + 1 : 1;
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", 32'(busy), 32'(m_busy_left != 0));
            check("cyc_segments", 32'(segments), 32'(m_seg));
            check("cyc_digit_en", 32'(digit_en), 32'(m_dig));
        end
    end

    // ---------------------------------------------------------------- tasks
    task automatic do_load(input logic [WIDTH-1:0] v, input logic m, input logic s);
        @(negedge clk);
        value     = v;
        mode      = m;
        signed_en = s;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    task automatic count_busy(input string name, input int expected);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(name, 32'(n), 32'(expected));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("idle_wait", 32'(busy), 32'd0);
    endtask

    // Visits each digit position in turn and checks its glyph literally.
    task automatic check_display(input string name, input disp_t exp);
        logic [DIGITS-1:0] want;
        int n;
        @(negedge clk);
        for (int d = 0; d < DIGITS; d++) begin
            want = ~(DIGITS'(1) << d);
            n = 0;
            while (digit_en !== want && n < 32) begin
                n++;
                @(negedge clk);
            end
            check({name, "_sel"}, 32'(digit_en), 32'(want));
            check($sformatf("%s_d%0d", name, d), 32'(segments), 32'(exp[d]));
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    typedef struct {
        logic [WIDTH-1:0] v;
        logic             m;
        logic             s;
    } vec_t;

    vec_t extra [12] = '{
        '{8'h12, 1'b0, 1'b0}, '{8'h34, 1'b0, 1'b0}, '{8'h56, 1'b0, 1'b0},
        '{8'h78, 1'b0, 1'b0}, '{8'h9A, 1'b0, 1'b1}, '{8'hDE, 1'b0, 1'b0},
        '{8'd0,  1'b1, 1'b0}, '{8'd100, 1'b1, 1'b0}, '{8'hFF, 1'b1, 1'b1},
        '{8'h7F, 1'b1, 1'b1}, '{8'h9C, 1'b1, 1'b1}, '{8'hCE, 1'b1, 1'b1}
    };

    logic [DIGITS-1:0] scan_pat [3] = '{3'b110, 3'b101, 3'b011};

    initial begin
        logic [DIGITS-1:0] prev;
        int n;

        rst = 1'b1; value = '0; mode = 1'b0; signed_en = 1'b0; load = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Reset state, literal.
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_segments", 32'(segments), 32'h7F);
        check("rst_digit_en", 32'(digit_en), 32'(3'b110));

        // Hex 3C: one busy cycle, digits 0/3/C.
        do_load(8'h3C, 1'b0, 1'b0);
        count_busy("hex_busy_len", 1);
        check_display("hex_3c", {7'b0000001, 7'b0000110, 7'b0110001});

        // Decimal 255: nine busy cycles, digits 2/5/5.
        do_load(8'd255, 1'b1, 1'b0);
        count_busy("dec_busy_len", WIDTH + 1);
        check_display("dec_255", {7'b0010010, 7'b0100100, 7'b0100100});

        // Decimal 7 with leading-zero blanking.
        do_load(8'd7, 1'b1, 1'b0);
        wait_idle();
        check_display("dec_7", {G_BLANK, G_BLANK, 7'b0001111});

        // Signed -10 and the -128 overflow.
        do_load(8'hF6, 1'b1, 1'b1);
        wait_idle();
        check_display("sgn_m10", {G_MINUS, 7'b1001111, 7'b0000001});
        do_load(8'h80, 1'b1, 1'b1);
        wait_idle();
        check_display("sgn_m128", {G_MINUS, G_MINUS, G_MINUS});

        // Scan pattern: each select held SCAN_DIV cycles, in order 0,1,2.
        prev = digit_en;
        n = 0;
        while (!(digit_en === 3'b110 && prev !== 3'b110) && n < 32) begin
            prev = digit_en;
            n++;
            @(negedge clk);
        end
        for (int i = 0; i < 3 * SCAN_DIV; i++) begin
            check("scan_pattern", 32'(digit_en), 32'(scan_pat[i / SCAN_DIV]));
            @(negedge clk);
        end

        // Load during CONV is dropped.
        do_load(8'd200, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        do_load(8'd1, 1'b1, 1'b0);
        wait_idle();
        check_display("busy_drop", {7'b0010010, 7'b0000001, 7'b0000001});

        // load held high: accepted, ignored on FORMAT exit, accepted again
        // on the first idle edge with the new value.
        @(negedge clk);
        value = 8'hA5; mode = 1'b0; signed_en = 1'b0; load = 1'b1;
        @(negedge clk);
        value = 8'hC7;
        @(negedge clk);
        @(negedge clk);
        load = 1'b0;
        wait_idle();
        check_display("b2b_hex", {7'b0000001, 7'b0110001, 7'b0001111});

        // Hex and decimal sweep, checked by the per-cycle model.
        for (int k = 0; k < 12; k++) begin
            do_load(extra[k].v, extra[k].m, extra[k].s);
            wait_idle();
            repeat (16) @(negedge clk);
        end

        // Reset during the 4th CONV cycle aborts with no buffer write.
        do_load(8'd123, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_segments", 32'(segments), 32'h7F);
        check("abort_digit_en", 32'(digit_en), 32'(3'b110));
        repeat (12) @(negedge clk);
        check_display("abort_blank", {G_BLANK, G_BLANK, G_BLANK});

        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
